mc_control: RTL and testbench

Multicycle control unit for the single-ALU MIPS datapath. It holds the instruction-sequencing state machine and drives every datapath control each cycle: PC/IR/register-file/memory enables, mux selects, and the 3-bit ALU operation code. It sits beside the datapath, reading the IR opcode/funct fields, the ALU zero flag and a memory-ready handshake. One ALU is time-shared across the PC increment, the branch target, the address and the execute steps.

---
 rtl/mc_control.sv | 214 +++++++++++++++++++++
 tb/tb_mc_control.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multicycle MIPS control unit: sequencing FSM and datapath controls.
// Optional addi support is built when MC_ADDI_EN is defined.
module mc_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal,
   output logic       retired,
   output logic [3:0] state
);

   localparam logic [2:0] op_and = 3'b000;
   localparam logic [2:0] op_or  = 3'b001;
   localparam logic [2:0] op_add = 3'b010;
   localparam logic [2:0] op_sub = 3'b110;
   localparam logic [2:0] op_slt = 3'b111;

   typedef enum logic [3:0] {
      st_fetch  = 4'd0,
      st_decode = 4'd1,
      st_memadr = 4'd2,
      st_memrd  = 4'd3,
      st_memwb  = 4'd4,
      st_memwr  = 4'd5,
      st_exec   = 4'd6,
      st_aluwb  = 4'd7,
      st_branch = 4'd8,
      st_jump   = 4'd9
`ifdef MC_ADDI_EN
      ,
      st_addiex = 4'd10,
      st_addiwb = 4'd11
`endif
   } state_t;

   state_t cur;
   state_t nxt;
   logic   is_sw;
   logic   funct_ok;

   assign funct_ok = funct inside {6'b100000, 6'b100010, 6'b100100,
                                   6'b100101, 6'b101010};

   // state register; reset abandons any partial instruction
   always_ff @(posedge clk) begin
      if (reset)
         cur <= st_fetch;
      else
         cur <= nxt;
   end

   // remember lw vs sw so opcode is only looked at during decode
   always_ff @(posedge clk) begin
      if (reset)
         is_sw <= 1'b0;
      else if (cur == st_decode)
         is_sw <= (opcode == 6'b101011);
   end

   // next-state and control outputs; reset forces everything low
   always_comb begin
      nxt        = cur;
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = op_add;
      pc_source  = 2'b00;
      illegal    = 1'b0;
      retired    = 1'b0;
      state      = cur;
      case (cur)
         st_fetch: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready)
               nxt = st_decode;
         end
         st_decode: begin
            alu_src_b = 2'b11;
            case (opcode)
               6'b100011, 6'b101011: nxt = st_memadr;
               6'b000000: begin
                  if (funct_ok) begin
                     nxt = st_exec;
                  end else begin
                     illegal = 1'b1;
                     nxt     = st_fetch;
                  end
               end
               6'b000100: nxt = st_branch;
               6'b000010: nxt = st_jump;
`ifdef MC_ADDI_EN
               6'b001000: nxt = st_addiex;
`endif
               default: begin
                  illegal = 1'b1;
                  nxt     = st_fetch;
               end
            endcase
         end
         st_memadr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt       = is_sw ? st_memwr : st_memrd;
         end
         st_memrd: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready)
               nxt = st_memwb;
         end
         st_memwb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retired    = 1'b1;
            nxt        = st_fetch;
         end
         st_memwr: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            retired   = mem_ready;
            if (mem_ready)
               nxt = st_fetch;
         end
         st_exec: begin
            alu_src_a = 1'b1;
            case (funct)
               6'b100010: alu_op = op_sub;
               6'b100100: alu_op = op_and;
               6'b100101: alu_op = op_or;
               6'b101010: alu_op = op_slt;
               default:   alu_op = op_add;
            endcase
            nxt = st_aluwb;
         end
         st_aluwb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retired   = 1'b1;
            nxt       = st_fetch;
         end
         st_branch: begin
            alu_src_a = 1'b1;
            alu_op    = op_sub;
            pc_source = 2'b01;
            pc_write  = zero;
            retired   = 1'b1;
            nxt       = st_fetch;
         end
         st_jump: begin
            pc_source = 2'b10;
            pc_write  = 1'b1;
            retired   = 1'b1;
            nxt       = st_fetch;
         end
`ifdef MC_ADDI_EN
         st_addiex: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt       = st_addiwb;
         end
         st_addiwb: begin
            reg_write = 1'b1;
            retired   = 1'b1;
            nxt       = st_fetch;
         end
`endif
         default: nxt = st_fetch;
      endcase
      if (reset) begin
         nxt        = st_fetch;
         pc_write   = 1'b0;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         alu_op     = 3'b000;
         pc_source  = 2'b00;
         illegal    = 1'b0;
         retired    = 1'b0;
         state      = 4'd0;
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: instruction-level trace model plus length check.
// Honors MC_ADDI_EN the same way as the design.
module tb_mc_control;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, iord, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal, retired;
   logic [3:0] state;

   typedef struct packed {
      logic       pc_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal;
      logic       retired;
      logic [3:0] state;
   } cyc_t;

   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3;
   localparam int K_J = 4, K_ADDI = 5, K_ILL = 6;

   cyc_t       act;
   cyc_t       exp_q[$];
   int         len_q[$];
   int         ncmp;
   int         nerr;
   int         run_len;
   logic [5:0] p_op;
   logic [5:0] p_fn;
   logic       p_z;

   mc_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
      .illegal(illegal), .retired(retired), .state(state)
   );

   assign act = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, illegal, retired, state};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // per-cycle behaviour of each instruction phase
   function automatic cyc_t blank(input logic [3:0] s);
      cyc_t c;
      c        = '0;
      c.alu_op = 3'b010;
      c.state  = s;
      return c;
   endfunction

   function automatic cyc_t c_fetch(input logic mr);
      cyc_t c = blank(4'd0);
      c.mem_read  = 1'b1;
      c.alu_src_b = 2'b01;
      c.ir_write  = mr;
      c.pc_write  = mr;
      return c;
   endfunction

   function automatic cyc_t c_decode(input logic ill);
      cyc_t c = blank(4'd1);
      c.alu_src_b = 2'b11;
      c.illegal   = ill;
      return c;
   endfunction

   function automatic cyc_t c_addr(input logic [3:0] s);
      cyc_t c = blank(s);
      c.alu_src_a = 1'b1;
      c.alu_src_b = 2'b10;
      return c;
   endfunction

   function automatic cyc_t c_memrd();
      cyc_t c = blank(4'd3);
      c.mem_read = 1'b1;
      c.iord     = 1'b1;
      return c;
   endfunction

   function automatic cyc_t c_memwb();
      cyc_t c = blank(4'd4);
      c.reg_write  = 1'b1;
      c.mem_to_reg = 1'b1;
      c.retired    = 1'b1;
      return c;
   endfunction

   function automatic cyc_t c_memwr(input logic mr);
      cyc_t c = blank(4'd5);
      c.mem_write = 1'b1;
      c.iord      = 1'b1;
      c.retired   = mr;
      return c;
   endfunction

   function automatic cyc_t c_exec(input logic [2:0] op);
      cyc_t c = blank(4'd6);
      c.alu_src_a = 1'b1;
      c.alu_op    = op;
      return c;
   endfunction

   function automatic cyc_t c_wb(input logic [3:0] s, input logic rd);
      cyc_t c = blank(s);
      c.reg_write = 1'b1;
      c.reg_dst   = rd;
      c.retired   = 1'b1;
      return c;
   endfunction

   function automatic cyc_t c_branch(input logic z);
      cyc_t c = blank(4'd8);
      c.alu_src_a = 1'b1;
      c.alu_op    = 3'b110;
      c.pc_source = 2'b01;
      c.pc_write  = z;
      c.retired   = 1'b1;
      return c;
   endfunction

   function automatic cyc_t c_jump();
      cyc_t c = blank(4'd9);
      c.pc_source = 2'b10;
      c.pc_write  = 1'b1;
      c.retired   = 1'b1;
      return c;
   endfunction

   function automatic int base_len(input int k);
      case (k)
         K_LW:    return 5;
         K_SW:    return 4;
         K_R:     return 4;
         K_BEQ:   return 3;
         K_J:     return 3;
         K_ADDI:  return 4;
         default: return 2;
      endcase
   endfunction

   // compare DUT against the model on the falling edge
   always @(negedge clk) begin
      cyc_t e;
      int   l;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         ncmp++;
         if (act !== e) begin
            nerr++;
            $display("FAIL trace t=%0t got=%h want=%h", $time, act, e);
         end
         if (reset) begin
            run_len = 0;
         end else begin
            run_len++;
            if (act.retired || act.illegal) begin
               ncmp++;
               if (len_q.size() == 0) begin
                  nerr++;
                  $display("FAIL len t=%0t got=%0d want=none",
                           $time, run_len);
               end else begin
                  l = len_q.pop_front();
                  if (run_len != l) begin
                     nerr++;
                     $display("FAIL len t=%0t got=%0d want=%0d",
                              $time, run_len, l);
                  end
               end
               run_len = 0;
            end
         end
      end
   end

   task automatic cycle(input logic rst, input logic mr, input cyc_t e);
      @(posedge clk);
      #1;
      reset     = rst;
      mem_ready = mr;
      opcode    = p_op;
      funct     = p_fn;
      zero      = p_z;
      exp_q.push_back(e);
   endtask

   task automatic run(input int k, input logic [5:0] op,
                      input logic [5:0] fn, input logic z,
                      input logic [2:0] rop, input int sf, input int sm);
      p_op = op;
      p_fn = fn;
      p_z  = z;
      len_q.push_back(base_len(k) + sf + sm);
      for (int i = 0; i < sf; i++) cycle(1'b0, 1'b0, c_fetch(1'b0));
      cycle(1'b0, 1'b1, c_fetch(1'b1));
      cycle(1'b0, 1'b1, c_decode(k == K_ILL));
      case (k)
         K_LW: begin
            cycle(1'b0, 1'b1, c_addr(4'd2));
            for (int i = 0; i < sm; i++) cycle(1'b0, 1'b0, c_memrd());
            cycle(1'b0, 1'b1, c_memrd());
            cycle(1'b0, 1'b1, c_memwb());
         end
         K_SW: begin
            cycle(1'b0, 1'b1, c_addr(4'd2));
            for (int i = 0; i < sm; i++)
               cycle(1'b0, 1'b0, c_memwr(1'b0));
            cycle(1'b0, 1'b1, c_memwr(1'b1));
         end
         K_R: begin
            cycle(1'b0, 1'b1, c_exec(rop));
            cycle(1'b0, 1'b1, c_wb(4'd7, 1'b1));
         end
         K_BEQ: cycle(1'b0, 1'b1, c_branch(z));
         K_J:   cycle(1'b0, 1'b1, c_jump());
         K_ADDI: begin
            cycle(1'b0, 1'b1, c_addr(4'd10));
            cycle(1'b0, 1'b1, c_wb(4'd11, 1'b0));
         end
         default: ;
      endcase
   endtask

   task automatic pin(input string nm, input cyc_t got, input cyc_t want);
      ncmp++;
      if (got !== want) begin
         nerr++;
         $display("FAIL pin_%s got=%h want=%h", nm, got, want);
      end
   endtask

   initial begin
      ncmp      = 0;
      nerr      = 0;
      run_len   = 0;
      reset     = 1'b1;
      mem_ready = 1'b1;
      opcode    = 6'd0;
      funct     = 6'd0;
      zero      = 1'b0;
      p_op      = 6'd0;
      p_fn      = 6'd0;
      p_z       = 1'b0;

      pin("fetch", c_fetch(1'b1),
          {9'b101010000, 2'b01, 3'b010, 2'b00, 2'b00, 4'd0});
      pin("decode_ill", c_decode(1'b1),
          {9'b000000000, 2'b11, 3'b010, 2'b00, 2'b10, 4'd1});
      pin("memwb", c_memwb(),
          {9'b000000110, 2'b00, 3'b010, 2'b00, 2'b01, 4'd4});
      pin("beq_taken", c_branch(1'b1),
          {9'b100000001, 2'b00, 3'b110, 2'b01, 2'b01, 4'd8});

      cycle(1'b1, 1'b1, '0);
      cycle(1'b1, 1'b1, '0);

      run(K_LW,  6'b100011, 6'd0, 1'b0, 3'b010, 0, 0);
      run(K_R,   6'b000000, 6'b101010, 1'b0, 3'b111, 0, 0);
      run(K_R,   6'b000000, 6'b100000, 1'b0, 3'b010, 0, 0);
      run(K_R,   6'b000000, 6'b100010, 1'b0, 3'b110, 0, 0);
      run(K_R,   6'b000000, 6'b100100, 1'b0, 3'b000, 0, 0);
      run(K_R,   6'b000000, 6'b100101, 1'b0, 3'b001, 0, 0);
      run(K_BEQ, 6'b000100, 6'd0, 1'b1, 3'b110, 0, 0);
      run(K_BEQ, 6'b000100, 6'd0, 1'b0, 3'b110, 0, 0);
      run(K_J,   6'b000010, 6'd0, 1'b0, 3'b010, 0, 0);
      run(K_SW,  6'b101011, 6'd0, 1'b0, 3'b010, 0, 3);
      run(K_LW,  6'b100011, 6'd0, 1'b0, 3'b010, 2, 1);
      run(K_ILL, 6'b111111, 6'd0, 1'b0, 3'b010, 0, 0);
      run(K_ILL, 6'b000000, 6'b000111, 1'b0, 3'b010, 0, 0);
`ifdef MC_ADDI_EN
      run(K_ADDI, 6'b001000, 6'd0, 1'b0, 3'b010, 0, 0);
`else
      run(K_ILL, 6'b001000, 6'd0, 1'b0, 3'b010, 0, 0);
`endif

      p_op = 6'b101011;
      p_fn = 6'd0;
      p_z  = 1'b0;
      cycle(1'b0, 1'b1, c_fetch(1'b1));
      cycle(1'b0, 1'b1, c_decode(1'b0));
      cycle(1'b0, 1'b1, c_addr(4'd2));
      cycle(1'b0, 1'b0, c_memwr(1'b0));
      cycle(1'b0, 1'b0, c_memwr(1'b0));
      cycle(1'b1, 1'b0, '0);

      run(K_J,   6'b000010, 6'd0, 1'b0, 3'b010, 1, 0);
      run(K_SW,  6'b101011, 6'd0, 1'b0, 3'b010, 0, 0);

      @(posedge clk);
      #10;
      ncmp++;
      if (len_q.size() != 0 || exp_q.size() != 0) begin
         nerr++;
         $display("FAIL drain got=%0d/%0d want=0/0",
                  len_q.size(), exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
